// File: rtl/vita_pkg.sv
// Shared fifo36 line layout and arbiter state encoding for the VITA TX chain.
package vita_pkg;

   // fifo36 line: [31:0] payload, [32] SOF, [33] EOF, [35:34] occupancy
   localparam int FIFO36_SOF     = 32;
   localparam int FIFO36_EOF     = 33;
   localparam int FIFO36_OCC_LSB = 34;

   // Arbiter state encoding
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT0 = 2'd1;
   localparam logic [1:0] ST_GRANT1 = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_GRANT0 = ST_GRANT0,
      S_GRANT1 = ST_GRANT1
   } arb_state_e;

endpackage

// File: rtl/vita_ctx_pkt_arbiter.sv
// Packet-atomic two-source arbiter for the context-packet output of the TX chain.
// src0 (error/ack) has priority; a starvation counter forces one src1 (flow-control)
// packet after STARVE_LIMIT consecutive src0 packets granted while src1 waited.
//
// Handshake: a line moves on a channel when that channel's valid (src_rdy) and
// ready (dst_rdy) are both high at a rising clk edge; valid never depends on ready,
// and a granted source's ready is the downstream ready passed straight through.
module vita_ctx_pkt_arbiter
   import vita_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_WIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [35:0]          data0_i,
   input  logic                 src0_rdy_i,
   output logic                 dst0_rdy_o,
   input  logic [35:0]          data1_i,
   input  logic                 src1_rdy_i,
   output logic                 dst1_rdy_o,
   output logic [35:0]          data_o,
   output logic                 src_rdy_o,
   input  logic                 dst_rdy_i,
   output logic [1:0]           grant_o,
   output logic [CNT_WIDTH-1:0] pkt_cnt0_o,
   output logic [CNT_WIDTH-1:0] pkt_cnt1_o
);

   // Starvation counter only needs to reach STARVE_LIMIT
   localparam int         SW         = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam bit         STARVE_EN  = (STARVE_LIMIT != 0);

   arb_state_e           state_q, state_d;
   logic [SW-1:0]        starve_q, starve_d;
   logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d;
   logic [CNT_WIDTH-1:0] cnt1_q, cnt1_d;
   logic                 clr_pend_q, clr_pend_d;

   assign pkt_cnt0_o = cnt0_q;
   assign pkt_cnt1_o = cnt1_q;

   // Next-state, counter updates and the zero-latency output mux
   always_comb begin
      state_d    = state_q;
      starve_d   = starve_q;
      cnt0_d     = cnt0_q;
      cnt1_d     = cnt1_q;
      clr_pend_d = clr_pend_q;
      data_o     = '0;
      src_rdy_o  = 1'b0;
      dst0_rdy_o = 1'b0;
      dst1_rdy_o = 1'b0;
      grant_o    = 2'b00;

      case (state_q)
         S_IDLE: begin
            // Arbitration uses the pre-clear starvation count
            if (src1_rdy_i && STARVE_EN && (starve_q == STARVE_MAX)) begin
               state_d = S_GRANT1;
            end else if (src0_rdy_i) begin
               state_d = S_GRANT0;
            end else if (src1_rdy_i) begin
               state_d = S_GRANT1;
            end
            if (clear || clr_pend_q) begin
               cnt0_d     = '0;
               cnt1_d     = '0;
               starve_d   = '0;
               clr_pend_d = 1'b0;
            end
         end

         S_GRANT0: begin
            data_o     = data0_i;
            src_rdy_o  = src0_rdy_i;
            dst0_rdy_o = dst_rdy_i;
            grant_o    = 2'b01;
            // A clear during a packet waits for the next IDLE cycle
            if (clear) clr_pend_d = 1'b1;
            if (src0_rdy_i && dst_rdy_i && data0_i[FIFO36_EOF]) begin
               state_d = S_IDLE;
               cnt0_d  = cnt0_q + 1'b1;
               if (src1_rdy_i) begin
                  if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
               end else begin
                  starve_d = '0;
               end
            end
         end

         S_GRANT1: begin
            data_o     = data1_i;
            src_rdy_o  = src1_rdy_i;
            dst1_rdy_o = dst_rdy_i;
            grant_o    = 2'b10;
            if (clear) clr_pend_d = 1'b1;
            if (src1_rdy_i && dst_rdy_i && data1_i[FIFO36_EOF]) begin
               state_d  = S_IDLE;
               cnt1_d   = cnt1_q + 1'b1;
               starve_d = '0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State, counters and pending-clear registers; reset beats clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         starve_q   <= '0;
         cnt0_q     <= '0;
         cnt1_q     <= '0;
         clr_pend_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         cnt0_q     <= cnt0_d;
         cnt1_q     <= cnt1_d;
         clr_pend_q <= clr_pend_d;
      end
   end

endmodule

// File: tb/tb_vita_ctx_pkt_arbiter.sv
// Directed bench for vita_ctx_pkt_arbiter: one task per scenario, inline checks.
module tb_vita_ctx_pkt_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic [35:0] data0_i = '0;
   logic        src0_rdy_i = 1'b0;
   logic        dst0_rdy_o;
   logic [35:0] data1_i = '0;
   logic        src1_rdy_i = 1'b0;
   logic        dst1_rdy_o;
   logic [35:0] data_o;
   logic        src_rdy_o;
   logic        dst_rdy_i = 1'b0;
   logic [1:0]  grant_o;
   logic [15:0] pkt_cnt0_o;
   logic [15:0] pkt_cnt1_o;

   // Second instance with narrow counters for the wrap scenario
   logic        w_clear = 1'b0;
   logic [35:0] w_data0 = '0;
   logic        w_src0_rdy = 1'b0;
   logic        w_dst0_rdy;
   logic [35:0] w_data1 = '0;
   logic        w_src1_rdy = 1'b0;
   logic        w_dst1_rdy;
   logic [35:0] w_data_o;
   logic        w_src_rdy_o;
   logic        w_dst_rdy = 1'b0;
   logic [1:0]  w_grant;
   logic [3:0]  w_cnt0;
   logic [3:0]  w_cnt1;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int dst_mode = 0;
   logic clr_req = 1'b0;
   logic both_rdy_seen = 1'b0;

   logic [35:0] q0[$];
   logic [35:0] q1[$];
   logic [35:0] out_q[$];
   logic [1:0]  gnt_q[$];

   vita_ctx_pkt_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(16)) u_dut (
      .clk(clk), .reset(reset), .clear(clear),
      .data0_i(data0_i), .src0_rdy_i(src0_rdy_i), .dst0_rdy_o(dst0_rdy_o),
      .data1_i(data1_i), .src1_rdy_i(src1_rdy_i), .dst1_rdy_o(dst1_rdy_o),
      .data_o(data_o), .src_rdy_o(src_rdy_o), .dst_rdy_i(dst_rdy_i),
      .grant_o(grant_o), .pkt_cnt0_o(pkt_cnt0_o), .pkt_cnt1_o(pkt_cnt1_o)
   );

   vita_ctx_pkt_arbiter #(.STARVE_LIMIT(4), .CNT_WIDTH(4)) u_dut4 (
      .clk(clk), .reset(reset), .clear(w_clear),
      .data0_i(w_data0), .src0_rdy_i(w_src0_rdy), .dst0_rdy_o(w_dst0_rdy),
      .data1_i(w_data1), .src1_rdy_i(w_src1_rdy), .dst1_rdy_o(w_dst1_rdy),
      .data_o(w_data_o), .src_rdy_o(w_src_rdy_o), .dst_rdy_i(w_dst_rdy),
      .grant_o(w_grant), .pkt_cnt0_o(w_cnt0), .pkt_cnt1_o(w_cnt1)
   );

   // Clock
   always #5 clk = ~clk;

   function automatic logic [35:0] mk(input logic [31:0] p, input logic sof, input logic eof);
      return {2'b00, eof, sof, p};
   endfunction

   function automatic int eof_count();
      int n = 0;
      foreach (out_q[i]) if (out_q[i][33]) n++;
      return n;
   endfunction

   // Drive sources from their queues, observe output transfers on the falling edge
   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cyc++;
         clear      = clr_req;
         clr_req    = 1'b0;
         src0_rdy_i = (q0.size() > 0);
         data0_i    = (q0.size() > 0) ? q0[0] : '0;
         src1_rdy_i = (q1.size() > 0);
         data1_i    = (q1.size() > 0) ? q1[0] : '0;
         dst_rdy_i  = (dst_mode == 0) ? 1'b1 : cyc[0];
         @(negedge clk);
         if (src_rdy_o && dst_rdy_i) begin
            out_q.push_back(data_o);
            gnt_q.push_back(grant_o);
         end
         if (src0_rdy_i && dst0_rdy_o) void'(q0.pop_front());
         if (src1_rdy_i && dst1_rdy_o) void'(q1.pop_front());
         if (dst0_rdy_o && dst1_rdy_o) both_rdy_seen = 1'b1;
      end
   endtask

   task automatic run_until_eofs(input int n, input int max_cyc, input string name);
      int k = 0;
      while (eof_count() < n && k < max_cyc) begin
         run_cycles(1);
         k++;
      end
      checks++;
      if (eof_count() < n) begin
         errors++;
         $display("FAIL %s timeout: eofs=%0d required=%0d", name, eof_count(), n);
      end
   endtask

   task automatic apply_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      src0_rdy_i = 1'b0; src1_rdy_i = 1'b0; clear = 1'b0;
      q0.delete(); q1.delete(); out_q.delete(); gnt_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic test_reset();
      src0_rdy_i = 1'b1; data0_i = mk(32'h11, 1'b1, 1'b1); dst_rdy_i = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant_o); end
      checks++; if (src_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_src_rdy got=%b exp=0", src_rdy_o); end
      checks++; if (dst0_rdy_o !== 1'b0 || dst1_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_dst_rdy got=%b%b exp=00", dst0_rdy_o, dst1_rdy_o); end
      checks++; if (data_o !== 36'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data_o); end
      checks++; if (pkt_cnt0_o !== 16'd0 || pkt_cnt1_o !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", pkt_cnt0_o, pkt_cnt1_o); end
      apply_reset();
   endtask

   task automatic test_single_src0();
      logic [35:0] exp_q[$];
      exp_q = '{mk(32'hA0, 1, 0), mk(32'hA1, 0, 0), mk(32'hA2, 0, 1)};
      dst_mode = 0;
      foreach (exp_q[i]) q0.push_back(exp_q[i]);
      run_cycles(1);
      checks++; if (src_rdy_o !== 1'b0 || grant_o !== 2'b00) begin errors++; $display("FAIL single_idle src_rdy=%b grant=%b exp=0/00", src_rdy_o, grant_o); end
      run_cycles(1);
      checks++; if (grant_o !== 2'b01 || data_o !== exp_q[0]) begin errors++; $display("FAIL single_first grant=%b data=%h exp=01/%h", grant_o, data_o, exp_q[0]); end
      run_cycles(4);
      checks++; if (out_q.size() != 3) begin errors++; $display("FAIL single_len got=%0d exp=3", out_q.size()); end
      for (int i = 0; i < 3 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i] || gnt_q[i] !== 2'b01) begin
            errors++; $display("FAIL single_line%0d got=%h/%b exp=%h/01", i, out_q[i], gnt_q[i], exp_q[i]);
         end
      end
      checks++; if (pkt_cnt0_o !== 16'd1 || grant_o !== 2'b00) begin errors++; $display("FAIL single_cnt cnt0=%0d grant=%b exp=1/00", pkt_cnt0_o, grant_o); end
   endtask

   task automatic test_starvation();
      logic [1:0] exp_g[10];
      logic [1:0] got_g[$];
      exp_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
      apply_reset();
      dst_mode = 0;
      for (int p = 0; p < 10; p++) begin
         q0.push_back(mk(32'h0000_0100 + p, 1, 0));
         q0.push_back(mk(32'h0000_0180 + p, 0, 1));
      end
      for (int p = 0; p < 3; p++) begin
         q1.push_back(mk(32'h0000_0200 + p, 1, 0));
         q1.push_back(mk(32'h0000_0280 + p, 0, 1));
      end
      run_until_eofs(10, 60, "starve_run");
      q0.delete(); q1.delete();
      run_cycles(2);
      foreach (out_q[i]) if (out_q[i][33]) got_g.push_back(gnt_q[i]);
      for (int p = 0; p < 10; p++) begin
         checks++;
         if (p >= got_g.size() || got_g[p] !== exp_g[p]) begin
            errors++; $display("FAIL starve_grant%0d got=%b exp=%b", p, (p < got_g.size()) ? got_g[p] : 2'bxx, exp_g[p]);
         end
      end
      checks++; if (pkt_cnt0_o !== 16'd8 || pkt_cnt1_o !== 16'd2) begin errors++; $display("FAIL starve_cnt got=%0d/%0d exp=8/2", pkt_cnt0_o, pkt_cnt1_o); end
      checks++; if (out_q.size() != 20) begin errors++; $display("FAIL starve_lines got=%0d exp=20", out_q.size()); end
   endtask

   task automatic test_backpressure();
      logic [35:0] exp_q[$];
      apply_reset();
      dst_mode = 1;
      for (int i = 0; i < 5; i++) exp_q.push_back(mk(32'hB0 + i, i == 0, i == 4));
      foreach (exp_q[i]) q1.push_back(exp_q[i]);
      run_cycles(1);
      q0.push_back(mk(32'hC0, 1, 0));
      q0.push_back(mk(32'hC1, 0, 1));
      run_until_eofs(1, 40, "bp_src1");
      checks++; if (out_q.size() != 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", out_q.size()); end
      for (int i = 0; i < 5 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i] || gnt_q[i] !== 2'b10) begin
            errors++; $display("FAIL bp_line%0d got=%h/%b exp=%h/10", i, out_q[i], gnt_q[i], exp_q[i]);
         end
      end
      run_until_eofs(2, 40, "bp_src0");
      run_cycles(2);
      checks++; if (pkt_cnt0_o !== 16'd1 || pkt_cnt1_o !== 16'd1) begin errors++; $display("FAIL bp_cnt got=%0d/%0d exp=1/1", pkt_cnt0_o, pkt_cnt1_o); end
      checks++; if (out_q.size() != 7) begin errors++; $display("FAIL bp_total got=%0d exp=7", out_q.size()); end
      dst_mode = 0;
   endtask

   task automatic test_clear_mid_packet();
      logic [35:0] exp_q[$];
      out_q.delete(); gnt_q.delete();
      dst_mode = 0;
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'hD0 + i, i == 0, i == 3));
      foreach (exp_q[i]) q0.push_back(exp_q[i]);
      run_cycles(2);
      clr_req = 1'b1;
      run_cycles(1);
      run_until_eofs(1, 10, "clr_pkt");
      run_cycles(1);
      checks++; if (grant_o !== 2'b00 || pkt_cnt0_o !== 16'd2) begin errors++; $display("FAIL clr_pending grant=%b cnt0=%0d exp=00/2", grant_o, pkt_cnt0_o); end
      run_cycles(1);
      checks++; if (pkt_cnt0_o !== 16'd0 || pkt_cnt1_o !== 16'd0) begin errors++; $display("FAIL clr_applied got=%0d/%0d exp=0/0", pkt_cnt0_o, pkt_cnt1_o); end
      checks++; if (out_q.size() != 4) begin errors++; $display("FAIL clr_len got=%0d exp=4", out_q.size()); end
      for (int i = 0; i < 4 && i < out_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL clr_line%0d got=%h exp=%h", i, out_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid_packet();
      q0.push_back(mk(32'hE0, 1, 0));
      q0.push_back(mk(32'hE1, 0, 0));
      q0.push_back(mk(32'hE2, 0, 1));
      q1.push_back(mk(32'hEE, 1, 0));
      run_cycles(2);
      checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL rstmid_pre grant=%b exp=01", grant_o); end
      run_cycles(1);
      @(posedge clk); #1 reset = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      q0.delete(); q1.delete(); out_q.delete(); gnt_q.delete();
      src0_rdy_i = 1'b0; src1_rdy_i = 1'b0; data0_i = '0; data1_i = '0;
      @(negedge clk);
      checks++;
      if (grant_o !== 2'b00 || src_rdy_o !== 1'b0 || dst0_rdy_o !== 1'b0 || dst1_rdy_o !== 1'b0 || data_o !== 36'h0) begin
         errors++; $display("FAIL rstmid_outputs grant=%b src_rdy=%b dst=%b%b data=%h exp=00/0/00/0", grant_o, src_rdy_o, dst0_rdy_o, dst1_rdy_o, data_o);
      end
      checks++; if (pkt_cnt0_o !== 16'd0 || pkt_cnt1_o !== 16'd0) begin errors++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", pkt_cnt0_o, pkt_cnt1_o); end
      q1.push_back(mk(32'hF0, 1, 1));
      run_cycles(3);
      checks++; if (out_q.size() != 1 || out_q[0] !== mk(32'hF0, 1, 1)) begin errors++; $display("FAIL rstmid_fresh size=%0d first=%h exp=1/%h", out_q.size(), (out_q.size() > 0) ? out_q[0] : 36'h0, mk(32'hF0, 1, 1)); end
      checks++; if (pkt_cnt1_o !== 16'd1 || pkt_cnt0_o !== 16'd0) begin errors++; $display("FAIL rstmid_cnt1 got=%0d/%0d exp=0/1", pkt_cnt0_o, pkt_cnt1_o); end
   endtask

   task automatic test_wrap();
      int n = 0;
      int k = 0;
      @(posedge clk); #1;
      w_data1 = mk(32'h77, 1, 1);
      w_src1_rdy = 1'b1;
      w_dst_rdy = 1'b1;
      while (n < 17 && k < 100) begin
         @(negedge clk);
         if (w_src_rdy_o && w_dst_rdy) n++;
         @(posedge clk); #1;
         k++;
      end
      w_src1_rdy = 1'b0;
      checks++; if (n != 17) begin errors++; $display("FAIL wrap_count got=%0d exp=17", n); end
      @(negedge clk);
      checks++; if (w_cnt1 !== 4'd1 || w_cnt0 !== 4'd0) begin errors++; $display("FAIL wrap_cnt got=%0d/%0d exp=0/1", w_cnt0, w_cnt1); end
   endtask

   initial begin
      test_reset();
      test_single_src0();
      test_starvation();
      test_backpressure();
      test_clear_mid_packet();
      test_reset_mid_packet();
      test_wrap();
      checks++; if (both_rdy_seen !== 1'b0) begin errors++; $display("FAIL dual_ready got=%b exp=0", both_rdy_seen); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
